stop_watch_lap: RTL and testbench

//   Parametrised BCD stopwatch with lap capture and a configurable end-of-range mode.
//   A prescaler divides clk down to a count tick. An N-digit BCD counter advances on each tick.
//   A lap register can freeze the displayed value while the counter keeps running.

---
 rtl/stop_watch_lap.sv | 106 ++++++++++
 tb/tb_stop_watch_lap.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_lap.sv
// BCD stopwatch: prescaled tick drives an N-digit BCD counter, with lap freeze and wrap/saturate end mode.
// Latency: count, tick and ovf update on the same edge, d is a pure mux of registers; no backpressure (go is a level enable).
module stop_watch_lap #(
  parameter int DVSR       = 5000000,
  parameter int NUM_DIGITS = 3,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    clr,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] d,
  output logic                    running,
  output logic                    lap_active,
  output logic                    tick,
  output logic                    ovf
);

  localparam int PW = $clog2(DVSR);
  localparam logic [PW-1:0] PRE_LAST = PW'(DVSR - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                  state;
  logic [PW-1:0]           prescale;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] lap_reg;
  logic [4*NUM_DIGITS-1:0] count_inc;
  logic                    all_nines;
  logic                    carry;
  logic                    cnt_en;
  logic                    pre_tick;

  // The prescaler advances on every cycle that go is sampled high outside DONE,
  // including the cycle that moves IDLE/PAUSED into RUN.
  always_comb begin
    cnt_en   = go && (state != DONE);
    pre_tick = cnt_en && (prescale == PRE_LAST);
  end

  // Ripple BCD increment; an all-nines count naturally rolls to zero.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (count[4*k +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (count[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state      <= IDLE;
      prescale   <= '0;
      count      <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      running    <= 1'b0;
      tick       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      tick <= pre_tick;
      ovf  <= pre_tick && all_nines;

      if (cnt_en) prescale <= pre_tick ? '0 : prescale + PW'(1);

      // Lap samples the pre-edge count, so a coincident tick is not included.
      if (lap) begin
        if (state == RUN) begin
          lap_reg    <= count;
          lap_active <= 1'b1;
        end else begin
          lap_active <= 1'b0;
        end
      end

      case (state)
        IDLE:    if (go)  begin state <= RUN;    running <= 1'b1; end
        RUN:     if (!go) begin state <= PAUSED; running <= 1'b0; end
        PAUSED:  if (go)  begin state <= RUN;    running <= 1'b1; end
        default: ;
      endcase

      if (pre_tick) begin
        if (all_nines && (SATURATE != 0)) begin
          state   <= DONE;
          running <= 1'b0;
        end else begin
          count <= count_inc;
        end
      end
    end
  end

  assign d = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Bench for stop_watch_lap: wrapping and saturating instances share stimulus and are
// compared every cycle against a decimal-integer reference model.
module tb_stop_watch_lap;

  localparam int DVSR = 4;
  localparam int ND   = 3;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  logic reset = 1'b0, go = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [4*ND-1:0] d_w, d_s;
  logic run_w, run_s, la_w, la_s, tick_w, tick_s, ovf_w, ovf_s;

  int checks = 0;
  int failures = 0;
  int ovf_cnt_w, ovf_cnt_s, tick_cnt_w;

  // Reference model state, index 0 = wrapping instance, 1 = saturating instance.
  // mode: 0 idle, 1 run, 2 paused, 3 done
  int m_mode[2], m_phase[2], m_val[2], m_lapv[2];
  bit m_lapon[2], m_tick[2], m_ovf[2];

  always #5 clk = ~clk;

  stop_watch_lap #(.DVSR(DVSR), .NUM_DIGITS(ND), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .lap(lap),
    .d(d_w), .running(run_w), .lap_active(la_w), .tick(tick_w), .ovf(ovf_w));

  stop_watch_lap #(.DVSR(DVSR), .NUM_DIGITS(ND), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .lap(lap),
    .d(d_s), .running(run_s), .lap_active(la_s), .tick(tick_s), .ovf(ovf_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic model_step(input int i, input bit sat);
    bit t;
    m_tick[i] = 1'b0;
    m_ovf[i]  = 1'b0;
    if (reset || clr) begin
      m_mode[i] = 0; m_phase[i] = 0; m_val[i] = 0; m_lapv[i] = 0; m_lapon[i] = 1'b0;
      return;
    end
    t = 1'b0;
    if (go && m_mode[i] != 3) begin
      m_phase[i]++;
      if (m_phase[i] == DVSR) begin
        m_phase[i] = 0;
        t = 1'b1;
      end
    end
    if (lap) begin
      if (m_mode[i] == 1) begin
        m_lapv[i]  = m_val[i];
        m_lapon[i] = 1'b1;
      end else begin
        m_lapon[i] = 1'b0;
      end
    end
    if ((m_mode[i] == 0 || m_mode[i] == 2) && go) m_mode[i] = 1;
    else if (m_mode[i] == 1 && !go)               m_mode[i] = 2;
    if (t) begin
      m_tick[i] = 1'b1;
      if (m_val[i] == MAXV) begin
        m_ovf[i] = 1'b1;
        if (sat) m_mode[i] = 3;
        else     m_val[i] = 0;
      end else begin
        m_val[i] = m_val[i] + 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit g, input bit c, input bit l);
    int shown;
    reset = r; go = g; clr = c; lap = l;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    ovf_cnt_w  += int'(ovf_w);
    ovf_cnt_s  += int'(ovf_s);
    tick_cnt_w += int'(tick_w);
    shown = m_lapon[0] ? m_lapv[0] : m_val[0];
    chk("w_d",    d_w,    to_bcd(shown));
    chk("w_run",  run_w,  m_mode[0] == 1);
    chk("w_lap",  la_w,   m_lapon[0]);
    chk("w_tick", tick_w, m_tick[0]);
    chk("w_ovf",  ovf_w,  m_ovf[0]);
    shown = m_lapon[1] ? m_lapv[1] : m_val[1];
    chk("s_d",    d_s,    to_bcd(shown));
    chk("s_run",  run_s,  m_mode[1] == 1);
    chk("s_lap",  la_s,   m_lapon[1]);
    chk("s_tick", tick_s, m_tick[1]);
    chk("s_ovf",  ovf_s,  m_ovf[1]);
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_d", d_w, 12'h000);
    chk("reset_run", run_w, 0);

    // Continuous run: ten ticks in forty cycles, no overflow.
    ovf_cnt_w = 0; tick_cnt_w = 0;
    repeat (40) cyc(0, 1, 0, 0);
    chk("go40_d", d_w, 12'h010);
    chk("go40_run", run_w, 1);
    chk("go40_ticks", tick_cnt_w, 10);
    chk("go40_ovf", ovf_cnt_w, 0);

    // Pause keeps the partial prescaler period.
    cyc(0, 0, 1, 0);
    tick_cnt_w = 0;
    repeat (2) cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("pause_no_early_tick", tick_cnt_w, 0);
    cyc(0, 1, 0, 0);
    chk("pause_tick", tick_w, 1);
    chk("pause_ticks", tick_cnt_w, 1);
    chk("pause_d", d_w, 12'h001);

    // Lap freeze at 0x025 while the count advances, then release while paused.
    cyc(0, 0, 1, 0);
    repeat (100) cyc(0, 1, 0, 0);
    chk("pre_lap_d", d_w, 12'h025);
    cyc(0, 1, 0, 1);
    repeat (20) cyc(0, 1, 0, 0);
    chk("lap_hold_d", d_w, 12'h025);
    chk("lap_active", la_w, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("lap_release_d", d_w, 12'h030);
    chk("lap_release_la", la_w, 0);

    // Randomised traffic.
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 2000; i++) begin
      cyc(0, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
    end

    // End of range: 1000 ticks from zero.
    cyc(0, 0, 1, 0);
    ovf_cnt_w = 0; ovf_cnt_s = 0;
    repeat (4000) cyc(0, 1, 0, 0);
    chk("wrap_d", d_w, 12'h000);
    chk("wrap_run", run_w, 1);
    chk("wrap_ovf_cnt", ovf_cnt_w, 1);
    chk("sat_d", d_s, 12'h999);
    chk("sat_run", run_s, 0);
    chk("sat_ovf_cnt", ovf_cnt_s, 1);
    for (int i = 0; i < 20; i++) cyc(0, i[0], 0, 0);
    chk("sat_hold_d", d_s, 12'h999);
    chk("sat_hold_run", run_s, 0);
    chk("sat_hold_ovf_cnt", ovf_cnt_s, 1);
    cyc(0, 0, 1, 0);
    chk("sat_clr_d", d_s, 12'h000);
    chk("sat_clr_run", run_s, 0);

    // clr coinciding with tick and lap.
    repeat (4) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    repeat (2) cyc(0, 1, 0, 0);
    chk("pre_clr_la", la_w, 1);
    cyc(0, 1, 1, 1);
    chk("clr_tick", tick_w, 0);
    chk("clr_ovf", ovf_w, 0);
    chk("clr_d", d_w, 12'h000);
    chk("clr_la", la_w, 0);
    chk("clr_run", run_w, 0);
    tick_cnt_w = 0;
    repeat (3) cyc(0, 1, 0, 0);
    chk("restart_no_tick", tick_cnt_w, 0);
    cyc(0, 1, 0, 0);
    chk("restart_tick", tick_w, 1);
    chk("restart_d", d_w, 12'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
